vga_timing_gen: RTL and testbench

Raster timing generator that drives the scan position consumed by the scene renderers: it produces `h_count`, `v_count` and the per-frame `frame` toggle, plus the horizontal sync, vertical sync and display-enable signals for the video pins. The syncs are delayed so they stay aligned with the renderers' registered colour outputs. A start/stop handshake lets the top level hold the raster idle and stop only on a frame boundary.

---
 rtl/vga_timing_gen_pkg.sv | 47 ++++
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_timing_gen_delay_line.sv | 36 +++
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants, FSM state encoding and decode helpers for the
// VGA timing generator and the scene renderers that consume its position.
package vga_pkg;

  // Default 640x480@60 timing; renderers take H_ACTIVE/V_ACTIVE from here too.
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter widths are the port widths; they bound the legal totals.
  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;

  // Bit positions inside the 4-bit decode vector carried by the delay line.
  localparam int unsigned RAW_W  = 4;
  localparam int unsigned RAW_HS = 0;
  localparam int unsigned RAW_VS = 1;
  localparam int unsigned RAW_DE = 2;
  localparam int unsigned RAW_FS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_e;

  // Half-open window test lo <= val < hi, unsigned.
  function automatic logic in_window(input logic [15:0] val,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

  // Decode vector while idle or in reset: syncs deasserted, flags low.
  function automatic logic [3:0] raw_idle(input logic sync_active);
    return {1'b0, 1'b0, ~sync_active, ~sync_active};
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator (master) and its consumers
// (slave): run request in, scan position and delayed video controls out.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic                run;
  logic [H_CNT_W-1:0]  h_count;
  logic [V_CNT_W-1:0]  v_count;
  logic                frame;
  logic                busy;
  logic                hsync;
  logic                vsync;
  logic                display_on;
  logic                frame_start;

  modport master (
    input  run,
    output h_count, v_count, frame, busy, hsync, vsync, display_on, frame_start
  );

  modport slave (
    output run,
    input  h_count, v_count, frame, busy, hsync, vsync, display_on, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Parameterised-depth register chain used to align the sync/enable decodes
// with the renderers' colour latency. Depth 0 is a plain wire.
module vga_delay_line #(
  parameter int unsigned       DEPTH   = 1,
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the decode vector one stage per clock; reset flushes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan counters with a frame-boundary stop
// handshake, and sync/enable decodes delayed to match renderer latency.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP        = vga_pkg::H_FP,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned H_BP        = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP        = vga_pkg::V_FP,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter int unsigned V_BP        = vga_pkg::V_BP,
  parameter int unsigned PIPE_DELAY  = 1,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_timing_gen_if.master    vga
);
  import vga_pkg::*;

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOT - 1);
  localparam logic [15:0] HS_LO  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_HI  = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_LO  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_HI  = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] H_VIS  = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS  = 16'(V_ACTIVE);
  localparam logic [3:0]  RAW_IDLE = raw_idle(SYNC_ACTIVE);

  if (H_TOT > 2048) begin : g_h_total_too_big
    $error("vga_timing_gen: horizontal total exceeds 11-bit counter");
  end
  if (V_TOT > 1024) begin : g_v_total_too_big
    $error("vga_timing_gen: vertical total exceeds 10-bit counter");
  end
  if (PIPE_DELAY > 4) begin : g_delay_too_big
    $error("vga_timing_gen: PIPE_DELAY must be 0..4");
  end

  vga_state_e  state_q;
  logic [10:0] h_q;
  logic [9:0]  v_q;
  logic        frame_q;
  logic        busy_q;

  logic        h_end;
  logic        v_end;
  logic        frame_end;
  logic [10:0] h_adv;
  logic [9:0]  v_adv;
  logic [3:0]  raw_decode;
  logic [3:0]  raw_delayed;

  // Next raster position if the scan advances by one pixel this clock.
  always_comb begin
    h_end     = (h_q == H_LAST);
    v_end     = (v_q == V_LAST);
    frame_end = h_end && v_end;
    if (h_end) begin
      h_adv = 11'd0;
      v_adv = v_end ? 10'd0 : (v_q + 10'd1);
    end else begin
      h_adv = h_q + 11'd1;
      v_adv = v_q;
    end
  end

  // Run/stop FSM with counters, frame toggle and busy as registered outputs.
  // A stop request only takes effect at the frame wrap; run returning high
  // while draining cancels it without losing a pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= 11'd0;
      v_q     <= 10'd0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vga.run) begin
            state_q <= ST_SCAN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_SCAN: begin
          h_q <= h_adv;
          v_q <= v_adv;
          if (frame_end) frame_q <= ~frame_q;
          if (!vga.run) state_q <= ST_DRAIN;
          else          state_q <= ST_SCAN;
        end
        ST_DRAIN: begin
          h_q <= h_adv;
          v_q <= v_adv;
          if (frame_end) frame_q <= ~frame_q;
          if (vga.run) begin
            state_q <= ST_SCAN;
          end else if (frame_end) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          h_q     <= 11'd0;
          v_q     <= 10'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Undelayed sync/enable/frame-start decodes from the registered position.
  always_comb begin
    raw_decode = RAW_IDLE;
    if (state_q != ST_IDLE) begin
      raw_decode[RAW_HS] = in_window({5'd0, h_q}, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      raw_decode[RAW_VS] = in_window({6'd0, v_q}, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      raw_decode[RAW_DE] = ({5'd0, h_q} < H_VIS) && ({6'd0, v_q} < V_VIS);
      raw_decode[RAW_FS] = (h_q == 11'd0) && (v_q == 10'd0);
    end else begin
      raw_decode = RAW_IDLE;
    end
  end

  vga_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   (RAW_W),
    .RST_VAL (RAW_IDLE)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (raw_decode),
    .q_o   (raw_delayed)
  );

  assign vga.h_count     = h_q;
  assign vga.v_count     = v_q;
  assign vga.frame       = frame_q;
  assign vga.busy        = busy_q;
  assign vga.hsync       = raw_delayed[RAW_HS];
  assign vga.vsync       = raw_delayed[RAW_VS];
  assign vga.display_on  = raw_delayed[RAW_DE];
  assign vga.frame_start = raw_delayed[RAW_FS];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three generators (delays 0, 1, 3) on a shrunken raster
// checked every cycle against a linear-pixel-index model, plus literal checks.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;   // H total 30
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;   // V total 17
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FP = HT * VT;                      // 510 pixels per frame

  logic clk = 1'b0;
  logic rst_n;
  logic run;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if3 ();
  assign if0.run = run;
  assign if1.run = run;
  assign if3.run = run;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .PIPE_DELAY(0), .SYNC_ACTIVE(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .vga(if0));
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .PIPE_DELAY(1), .SYNC_ACTIVE(1'b0))
    dut1 (.clk(clk), .rst_n(rst_n), .vga(if1));
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .PIPE_DELAY(3), .SYNC_ACTIVE(1'b1))
    dut3 (.clk(clk), .rst_n(rst_n), .vga(if3));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: scanning flag, pending-stop flag and a linear pixel index.
  logic m_on, m_stop, m_frame;
  int   m_pix;

  // Model update on the same clock edge the DUTs sample run.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on <= 1'b0; m_stop <= 1'b0; m_pix <= 0; m_frame <= 1'b0;
    end else if (!m_on) begin
      if (run) m_on <= 1'b1;
    end else begin
      m_pix <= (m_pix == FP - 1) ? 0 : m_pix + 1;
      if (m_pix == FP - 1) m_frame <= ~m_frame;
      if (run) m_stop <= 1'b0;
      else if (!m_stop) m_stop <= 1'b1;
      else if (m_pix == FP - 1) begin m_on <= 1'b0; m_stop <= 1'b0; end
    end
  end

  // History of active-high decodes {fs,de,vs,hs}; index k = k cycles ago.
  logic [3:0] hist [5];
  logic [3:0] cur;
  int mh, mv;

  task automatic chk_dut(input string tag, input logic [10:0] hc, input logic [9:0] vc,
                         input logic fr, input logic bz, input logic hs, input logic vs,
                         input logic de, input logic fs, input logic sa, input logic [3:0] e);
    chk({tag, "_h_count"}, {21'd0, hc}, 32'(mh));
    chk({tag, "_v_count"}, {22'd0, vc}, 32'(mv));
    chk({tag, "_frame"}, {31'd0, fr}, {31'd0, m_frame});
    chk({tag, "_busy"}, {31'd0, bz}, {31'd0, m_on});
    chk({tag, "_hsync"}, {31'd0, hs}, {31'd0, e[0] ? sa : ~sa});
    chk({tag, "_vsync"}, {31'd0, vs}, {31'd0, e[1] ? sa : ~sa});
    chk({tag, "_display_on"}, {31'd0, de}, {31'd0, e[2]});
    chk({tag, "_frame_start"}, {31'd0, fs}, {31'd0, e[3]});
  endtask

  // Every-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    mh = m_pix % HT;
    mv = m_pix / HT;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) hist[i] = 4'd0;
    end else begin
      cur[0] = m_on && (mh >= HA + HF) && (mh < HA + HF + HS);
      cur[1] = m_on && (mv >= VA + VF) && (mv < VA + VF + VS);
      cur[2] = m_on && (mh < HA) && (mv < VA);
      cur[3] = m_on && (m_pix == 0);
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = cur;
    end
    chk_dut("d0", if0.h_count, if0.v_count, if0.frame, if0.busy, if0.hsync, if0.vsync,
            if0.display_on, if0.frame_start, 1'b0, hist[0]);
    chk_dut("d1", if1.h_count, if1.v_count, if1.frame, if1.busy, if1.hsync, if1.vsync,
            if1.display_on, if1.frame_start, 1'b0, hist[1]);
    chk_dut("d3", if3.h_count, if3.v_count, if3.frame, if3.busy, if3.hsync, if3.vsync,
            if3.display_on, if3.frame_start, 1'b1, hist[3]);
  end

  // Wait (at negedges) until the model reaches pixel (v,h) while scanning.
  task automatic wait_pos(input string name, input int v, input int h);
    int n;
    n = 0;
    while (!(m_on && m_pix == v * HT + h) && n < 3 * FP) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, (n < 3 * FP)}, 32'd1);
  endtask

  int cyc, n_de, n_fs, n_hs, n_vs, n;
  logic prev;
  logic all_busy;

  initial begin
    run = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle hold, then start latency.
    @(negedge clk);
    chk("idle_busy", {31'd0, if1.busy}, 32'd0);
    run = 1'b1;
    @(negedge clk);
    chk("start_h0", {21'd0, if1.h_count}, 32'd0);
    chk("start_busy", {31'd0, if1.busy}, 32'd1);
    chk("start_fs_d0", {31'd0, if0.frame_start}, 32'd1);
    @(negedge clk);
    chk("start_h1", {21'd0, if1.h_count}, 32'd1);

    // One full frame between frame toggles: period and per-frame counts.
    prev = if1.frame; n = 0;
    while (if1.frame == prev && n < 2 * FP) begin @(negedge clk); n++; end
    chk("first_toggle_seen", {31'd0, (n < 2 * FP)}, 32'd1);
    prev = if1.frame; cyc = 0; n_de = 0; n_fs = 0; n_hs = 0; n_vs = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (if1.display_on) n_de++;
      if (if1.frame_start) n_fs++;
      if (if1.hsync == 1'b0) n_hs++;
      if (if1.vsync == 1'b0) n_vs++;
    end while (if1.frame == prev && cyc < 2 * FP);
    chk("frame_period", 32'(cyc), 32'd510);
    chk("display_on_count", 32'(n_de), 32'd160);
    chk("frame_start_count", 32'(n_fs), 32'd1);
    chk("hsync_count", 32'(n_hs), 32'd102);
    chk("vsync_count", 32'(n_vs), 32'd60);

    // Stop at line 5: frame finishes, then idle at 0/0.
    wait_pos("wait_v5", 5, 0);
    run = 1'b0;
    n = 0;
    while (if1.busy && n < 2 * FP) begin @(negedge clk); n++; end
    chk("drain_cycles", 32'(n), 32'd360);
    chk("stop_h", {21'd0, if1.h_count}, 32'd0);
    chk("stop_v", {22'd0, if1.v_count}, 32'd0);

    // Cancel a stop mid-drain: no idle gap across the wrap.
    run = 1'b1;
    wait_pos("wait_v5_b", 5, 0);
    run = 1'b0;
    wait_pos("wait_v12", 12, 0);
    run = 1'b1;
    all_busy = 1'b1;
    repeat (2 * FP) begin @(negedge clk); all_busy = all_busy & if1.busy; end
    chk("cancel_no_gap", {31'd0, all_busy}, 32'd1);

    // Async reset inside hsync: outputs clear before the next edge.
    wait_pos("wait_hsync", 3, HA + HF + 2);
    chk("pre_rst_hsync_d0", {31'd0, if0.hsync}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_h_d0", {21'd0, if0.h_count}, 32'd0);
    chk("arst_v_d1", {22'd0, if1.v_count}, 32'd0);
    chk("arst_hsync_d0", {31'd0, if0.hsync}, 32'd1);
    chk("arst_hsync_d1", {31'd0, if1.hsync}, 32'd1);
    chk("arst_hsync_d3", {31'd0, if3.hsync}, 32'd0);
    chk("arst_busy_d3", {31'd0, if3.busy}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Randomized run levels with occasional asynchronous resets.
    for (int seg = 0; seg < 40; seg++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 1200)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        #($urandom_range(1, 4));
        rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
